// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with an iterative shift-add multiplier.
// Single-cycle ops finish on the accept edge. MUL runs WIDTH add/shift steps
// and then one extra cycle to transfer the accumulator into the result.
// Result and flags stay valid and stable in DONE until out_ready is seen.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    // The counter must be able to hold WIDTH itself, which marks the
    // extra transfer cycle that follows the last iteration.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Zero flag of a result word.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // Negative flag of a result word (two's-complement sign bit).
    function automatic logic is_neg(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    state_t                 state_r;
    state_t                 next_state_s;

    logic [2*WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]       mplier_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [CNT_W-1:0]       cnt_r;

    logic [WIDTH-1:0]       result_r;
    logic                   zero_r;
    logic                   negative_r;
    logic                   carry_r;
    logic                   overflow_r;
    logic                   out_valid_r;
    logic                   in_ready_r;

    logic                   accept_s;
    logic                   mul_last_s;
    logic [WIDTH-1:0]       b_op_s;
    logic                   cin_s;
    logic [WIDTH:0]         sum_s;
    logic                   add_ovf_s;
    logic                   slt_s;
    logic                   sltu_s;
    logic [WIDTH-1:0]       alu_res_s;
    logic                   alu_carry_s;
    logic                   alu_ovf_s;
    logic [2*WIDTH-1:0]     acc_next_s;

    assign accept_s   = in_valid && (state_r == ST_IDLE);
    assign mul_last_s = (cnt_r == CNT_LAST);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: IDLE -> MUL/DONE on accept, MUL -> DONE after the
    // transfer cycle, DONE -> IDLE when the consumer takes the result.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op == OP_MUL) begin
                        next_state_s = ST_MUL;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Shared adder: SUB is a + ~b + 1 so bit WIDTH is the no-borrow flag.
    always_comb begin
        b_op_s = b;
        cin_s  = 1'b0;
        if (op == OP_SUB) begin
            b_op_s = ~b;
            cin_s  = 1'b1;
        end else begin
            b_op_s = b;
            cin_s  = 1'b0;
        end
        sum_s     = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
        add_ovf_s = (a[WIDTH-1] == b_op_s[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != a[WIDTH-1]);
        // Compare directly rather than via the subtract sign, so SLT stays
        // correct when a-b overflows.
        slt_s  = ($signed(a) < $signed(b));
        sltu_s = (a < b);
    end

    // Single-cycle result and carry/overflow selection.
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (op)
            OP_AND: begin
                alu_res_s = a & b;
            end
            OP_OR: begin
                alu_res_s = a | b;
            end
            OP_ADD, OP_SUB: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = add_ovf_s;
            end
            OP_SLT: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
            end
            OP_NOR: begin
                alu_res_s = ~(a | b);
            end
            OP_SLTU: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, sltu_s};
            end
            OP_MUL: begin
                alu_res_s = {WIDTH{1'b0}};
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // One multiplier step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Datapath: operand latch, multiplier iteration and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r    <= {(2*WIDTH){1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (op == OP_MUL) begin
                            mcand_r  <= {{WIDTH{1'b0}}, a};
                            mplier_r <= b;
                            acc_r    <= {(2*WIDTH){1'b0}};
                            cnt_r    <= {CNT_W{1'b0}};
                        end else begin
                            result_r   <= alu_res_s;
                            zero_r     <= is_zero(alu_res_s);
                            negative_r <= is_neg(alu_res_s);
                            carry_r    <= alu_carry_s;
                            overflow_r <= alu_ovf_s;
                        end
                    end else begin
                        result_r <= result_r;
                    end
                end
                ST_MUL: begin
                    if (mul_last_s) begin
                        result_r   <= acc_r[WIDTH-1:0];
                        zero_r     <= is_zero(acc_r[WIDTH-1:0]);
                        negative_r <= is_neg(acc_r[WIDTH-1:0]);
                        carry_r    <= 1'b0;
                        overflow_r <= |acc_r[2*WIDTH-1:WIDTH];
                    end else begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= (next_state_s == ST_DONE);
            in_ready_r  <= (next_state_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed WIDTH=16 scenarios plus random sweeps at
// WIDTH=4 and WIDTH=32, all scored against a reference model via queues.
module tb_alu_seq;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        int          lat;
        int          acc_at;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_sw;

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        logic [63:0] t;
        t = v << (64 - w);
        return $signed(t) >>> (64 - w);
    endfunction

    // Reference model (valid for w <= 32), written from the op definitions.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [63:0] ai, input logic [63:0] bi);
        exp_t        e;
        logic [63:0] mask, a, b, r, p;
        longint      sa, sb, d, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        a = ai & mask;
        b = bi & mask;
        sa = sx(a, w);
        sb = sx(b, w);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        e.c = 1'b0;
        e.v = 1'b0;
        e.lat = 0;
        e.acc_at = 0;
        r = 64'd0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                r = (a + b) & mask;
                e.c = ((a + b) > mask);
                d = sa + sb;
                e.v = (d > smax) || (d < smin);
            end
            3'b011: begin
                r = (a - b) & mask;
                e.c = (a >= b);
                d = sa - sb;
                e.v = (d > smax) || (d < smin);
            end
            3'b100: r = (sa < sb) ? 64'd1 : 64'd0;
            3'b101: r = ~(a | b) & mask;
            3'b110: begin
                p = a * b;
                r = p & mask;
                e.v = ((p >> w) != 64'd0);
                e.lat = w + 1;
            end
            default: r = (a < b) ? 64'd1 : 64'd0;
        endcase
        e.res = r;
        e.z = (r == 64'd0);
        e.n = r[w-1];
        return e;
    endfunction

    // ---------------- WIDTH=16 directed DUT ----------------
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        zero, negative, carry, overflow;
    logic [15:0] a_i, b_i, result;
    logic [2:0]  op_i;
    exp_t        q16[$];
    logic        ovp16;

    alu_seq #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .op(op_i), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow)
    );

    // Scoreboard monitor for the 16-bit DUT.
    always @(negedge clk) begin
        if (!rst_n) begin
            ovp16 <= 1'b0;
        end else begin
            if (out_valid) begin
                if (q16.size() == 0) begin
                    check_val("w16 sb_empty", 64'(q16.size()), 64'd1);
                end else begin
                    if (!ovp16) check_val("w16 latency", 64'(cyc - q16[0].acc_at), 64'(q16[0].lat));
                    if (out_ready) begin
                        check_val("w16 result", 64'(result), q16[0].res);
                        check_val("w16 zero", 64'(zero), 64'(q16[0].z));
                        check_val("w16 negative", 64'(negative), 64'(q16[0].n));
                        check_val("w16 carry", 64'(carry), 64'(q16[0].c));
                        check_val("w16 overflow", 64'(overflow), 64'(q16[0].v));
                        q16.delete(0);
                    end
                end
            end
            ovp16 <= out_valid;
        end
    end

    task automatic drive16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        e = model(16, op, 64'(a), 64'(b));
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("w16 accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.acc_at = cyc + 1;
            q16.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        op_i = 3'($urandom);
    endtask

    task automatic drain16();
        int n;
        n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("w16 drain", 64'(q16.size()), 64'd0);
    endtask

    // ---------------- WIDTH=4 and WIDTH=32 random sweeps ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int W = (g == 0) ? 4 : 32;
        logic         iv, ir, ov, z, n, c, v;
        logic         ordy = 1'b1;
        logic [2:0]   opx;
        logic [W-1:0] ax, bx, res;
        exp_t         q[$];
        logic         ovp;
        bit           done = 1'b0;

        alu_seq #(.WIDTH(W)) u_dut (
            .clk(clk), .rst_n(rst_n_sw), .in_valid(iv), .in_ready(ir),
            .a(ax), .b(bx), .op(opx), .out_valid(ov), .out_ready(ordy),
            .result(res), .zero(z), .negative(n), .carry(c), .overflow(v)
        );

        // Random consumer backpressure, changed just after each edge.
        always @(posedge clk) ordy <= ($urandom_range(0, 3) != 0);

        // Scoreboard monitor for this width.
        always @(negedge clk) begin
            if (!rst_n_sw) begin
                ovp <= 1'b0;
            end else begin
                if (ov) begin
                    if (q.size() == 0) begin
                        check_val($sformatf("w%0d sb_empty", W), 64'(q.size()), 64'd1);
                    end else begin
                        if (!ovp) check_val($sformatf("w%0d latency", W), 64'(cyc - q[0].acc_at), 64'(q[0].lat));
                        if (ordy) begin
                            check_val($sformatf("w%0d result", W), 64'(res), q[0].res);
                            check_val($sformatf("w%0d zero", W), 64'(z), 64'(q[0].z));
                            check_val($sformatf("w%0d negative", W), 64'(n), 64'(q[0].n));
                            check_val($sformatf("w%0d carry", W), 64'(c), 64'(q[0].c));
                            check_val($sformatf("w%0d overflow", W), 64'(v), 64'(q[0].v));
                            q.delete(0);
                        end
                    end
                end
                ovp <= ov;
            end
        end

        // Random stimulus, ending with fixed boundary operands.
        initial begin
            exp_t         e;
            int           k;
            logic [W-1:0] ones;
            ones = '1;
            iv = 1'b0;
            ax = '0;
            bx = '0;
            opx = 3'd0;
            wait (rst_n_sw === 1'b1);
            for (int i = 0; i < 44; i++) begin
                @(negedge clk);
                iv = 1'b1;
                opx = 3'($urandom);
                ax = W'($urandom);
                bx = W'($urandom);
                if (i == 40) begin opx = 3'b110; ax = ones; bx = ones; end
                if (i == 41) begin opx = 3'b010; ax = ones; bx = W'(1); end
                if (i == 42) begin opx = 3'b100; ax = ones ^ (ones >> 1); bx = W'(1); end
                if (i == 43) begin opx = 3'b011; ax = W'(0); bx = W'(1); end
                e = model(W, opx, 64'(ax), 64'(bx));
                k = 0;
                while (!ir && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                if (!ir) begin
                    check_val($sformatf("w%0d accept_timeout", W), 64'(ir), 64'd1);
                end else begin
                    e.acc_at = cyc + 1;
                    q.push_back(e);
                end
                @(posedge clk);
                #1;
                iv = 1'b0;
                ax = W'($urandom);
                bx = W'($urandom);
                opx = 3'($urandom);
            end
            k = 0;
            while (q.size() != 0 && k < 400) begin
                @(negedge clk);
                k++;
            end
            check_val($sformatf("w%0d drain", W), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed sequence for the 16-bit DUT, then wait for the sweeps.
    initial begin
        int n;
        rst_n = 1'b0;
        rst_n_sw = 1'b0;
        in_valid = 1'b0;
        a_i = 16'd0;
        b_i = 16'd0;
        op_i = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst_n_sw = 1'b1;
        #1;
        check_val("rst result", 64'(result), 64'd0);
        check_val("rst zero", 64'(zero), 64'd0);
        check_val("rst negative", 64'(negative), 64'd0);
        check_val("rst carry", 64'(carry), 64'd0);
        check_val("rst overflow", 64'(overflow), 64'd0);
        check_val("rst out_valid", 64'(out_valid), 64'd0);
        check_val("rst in_ready", 64'(in_ready), 64'd1);

        drive16(3'b010, 16'h7FFF, 16'h0001);
        drive16(3'b011, 16'h0005, 16'h0005);
        drive16(3'b100, 16'h8000, 16'h0001);
        drive16(3'b111, 16'h8000, 16'h0001);
        drive16(3'b110, 16'h0100, 16'h0100);
        drive16(3'b110, 16'h00FF, 16'h0101);
        drive16(3'b000, 16'hF0F0, 16'h3C3C);
        drive16(3'b001, 16'hF0F0, 16'h0F0F);
        drive16(3'b011, 16'h8000, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            drive16(3'($urandom), 16'($urandom), 16'($urandom));
        end
        drain16();

        // Backpressure: result must hold while out_ready stays low.
        out_ready = 1'b0;
        drive16(3'b101, 16'h0F0F, 16'h00FF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp result", 64'(result), 64'h0000_0000_0000_F000);
            check_val("bp negative", 64'(negative), 64'd1);
            check_val("bp in_ready", 64'(in_ready), 64'd0);
            check_val("bp out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp in_ready_after", 64'(in_ready), 64'd1);
        drain16();

        // Reset in the middle of a multiply.
        drive16(3'b110, 16'h00FF, 16'h0101);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q16.delete();
        check_val("midrst result", 64'(result), 64'd0);
        check_val("midrst zero", 64'(zero), 64'd0);
        check_val("midrst negative", 64'(negative), 64'd0);
        check_val("midrst carry", 64'(carry), 64'd0);
        check_val("midrst overflow", 64'(overflow), 64'd0);
        check_val("midrst out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("midrst in_ready", 64'(in_ready), 64'd1);
        check_val("midrst out_valid_rel", 64'(out_valid), 64'd0);
        drive16(3'b010, 16'h0001, 16'h0001);
        drain16();

        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val("sweeps_done", 64'(g_sweep[0].done && g_sweep[1].done), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU: the registered, multi-cycle successor of the team's 16-bit combinational ripple ALU. It adds WIDTH generalisation, an iterative shift-add multiplier, a correct signed/unsigned set-less-than and registered flags. It sits between the register-file read stage and writeback, with valid/ready on both sides so multi-cycle ops can stall the datapath.

## Interface
- WIDTH, 16: operand/result width in bits; legal range 4 to 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an op.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 NOR, 110 MUL (unsigned, low half), 111 SLTU.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry out of MSB. SUB: no-borrow (a >= b unsigned). MUL and others: 0.
- overflow  out  1  ADD/SUB: signed overflow. MUL: high half of the full 2*WIDTH product is non-zero. Others: 0.

## Operation
- FSM states: IDLE, MUL, DONE. Reset state: IDLE.
- IDLE: in_ready=1, out_valid=0. Accept when in_valid&&in_ready.
  - For op != 110: compute combinationally, register result and flags, go to DONE.
  - For op 110: latch multiplicand=a, multiplier=b, clear the accumulator and iteration counter, go to MUL.
- MUL: in_ready=0. Each cycle: if multiplier[0], add multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right. The counter increments.
  - The accumulator is 2*WIDTH bits wide.
  - After exactly WIDTH iterations: result = accumulator[WIDTH-1:0]; overflow = |accumulator[2WIDTH-1:WIDTH]; go to DONE.
- DONE: out_valid=1, in_ready=0. Result and flags are held stable until out_ready=1. On that edge, go to IDLE.
- Arithmetic: SUB = a + ~b + 1 in WIDTH+1 bits; carry is bit WIDTH.
- ADD/SUB overflow: operand signs (b inverted for SUB) equal each other and differ from the result sign.
- SLT: result = {0…, ($signed(a) < $signed(b))}. It must be correct even when a-b overflows (e.g. a=0x8000, b=0x0001 gives 1).
- SLTU: unsigned compare, same result format.
- zero and negative are always derived from the registered result, for every op including MUL.
- Unused encodings: none. All 8 op codes are defined.
- in_valid while in_ready=0 is ignored; the source must hold it.
- a, b and op are sampled only on the accept edge. Later changes do not affect the op in flight.

## Timing
- Reset (async assert, any state): state=IDLE; result=0; zero=0, negative=0, carry=0, overflow=0; out_valid=0; in_ready=1 once rst_n is high. An in-flight MUL is aborted with no output.
- Deassertion is taken synchronously to clk. The first accept can occur on the first rising edge with rst_n high.
- Single-cycle ops: accepted on edge N; out_valid=1 after edge N. Earliest next accept is edge N+2 (the DONE→IDLE edge is N+1 if out_ready=1).
- MUL: accepted on edge N; out_valid=1 after edge N+WIDTH+1.
- Throughput: at most one op per 2 cycles. No back-to-back accept in DONE.
- out_ready held low: DONE persists indefinitely, and outputs do not change.
- Outputs are purely registered; there is no combinational path from inputs to outputs except none (in_ready depends on state only).

## Test plan
- Reset mid-MUL: WIDTH=16, accept MUL 0x00FF*0x0101. Assert rst_n low at cycle 5 -> all outputs 0 and in_ready=1 after release; the next ADD 1+1 gives result=2.
- ADD/SUB flags: ADD 0x7FFF+0x0001 -> result=0x8000, overflow=1, carry=0, negative=1. SUB 0x0005-0x0005 -> result=0, zero=1, carry=1, overflow=0.
- SLT vs SLTU: a=0x8000, b=0x0001. SLT -> result=1. SLTU -> result=0. Both give carry=0 and overflow=0.
- MUL latency and overflow: MUL 0x0100*0x0100 -> out_valid exactly 17 cycles after accept, result=0x0000, zero=1, overflow=1. MUL 0x00FF*0x0101 -> result=0xFFFF, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after NOR 0x0F0F,0x00FF -> result stays 0xF000 with negative=1; in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
- Parameter sweep: WIDTH=4 and WIDTH=32. Random ops checked against a reference model, including a MUL of all-ones*all-ones (overflow=1, result=1).
